// File: rtl/avst2axis_empty2keep.sv
// Avalon-ST to AXI-Stream bridge: converts empty to tkeep and flags packet framing violations.
// Latency 1 cycle through a 2-entry skid buffer; avst_ready is registered and drops only while the skid entry is full.
// Optional macro AVST2AXIS_PROTO_CNT_EN builds a saturating violation counter on proto_err_cnt.
module avst2axis_empty2keep #(
    parameter int DATA_W      = 512,
    parameter int NO_OF_BYTES = DATA_W / 8,
    parameter int EMPTY_BITS  = $clog2(NO_OF_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   avst_valid,
    output logic                   avst_ready,
    input  logic [DATA_W-1:0]      avst_data,
    input  logic                   avst_sop,
    input  logic                   avst_eop,
    input  logic [EMPTY_BITS-1:0]  avst_empty,
    input  logic                   avst_error,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [DATA_W-1:0]      axis_tdata,
    output logic [NO_OF_BYTES-1:0] axis_tkeep,
    output logic                   axis_tlast,
    output logic                   axis_tuser,
    output logic [15:0]            proto_err_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]      dat;
        logic [NO_OF_BYTES-1:0] keep;
        logic                   last;
        logic                   user;
    } beat_t;

    state_t r_state;
    beat_t  r_out;
    beat_t  r_skid;
    logic   r_out_vld;
    logic   r_skid_vld;
    logic   r_ready;
    logic   r_flag;

    beat_t  w_in;
    logic   w_acc;
    logic   w_xfer;
    logic   w_viol;
    logic   w_out_vld_nxt;
    logic   w_skid_vld_nxt;
    logic   w_sel_skid;
    logic   w_ld_in_out;
    logic   w_ld_skid;

    assign w_acc  = avst_valid && r_ready;
    assign w_xfer = r_out_vld && axis_tready;

    always_comb begin
        w_viol = w_acc && (((r_state == ST_IDLE) && !avst_sop) ||
                           ((r_state == ST_IN_PKT) && avst_sop));
        w_in      = '0;
        w_in.dat  = avst_data;
        w_in.last = avst_eop;
        for (int i = 0; i < NO_OF_BYTES; i++) begin
            w_in.keep[i] = !avst_eop || (i < (NO_OF_BYTES - int'(avst_empty)));
        end
        // Error status only travels on the closing beat of a packet.
        w_in.user = avst_eop && (avst_error || r_flag || w_viol);
    end

    // The skid entry is only ever full while r_ready is low, so no accept can coincide with a skid drain.
    always_comb begin
        w_out_vld_nxt  = r_out_vld;
        w_skid_vld_nxt = r_skid_vld;
        w_sel_skid     = 1'b0;
        w_ld_in_out    = 1'b0;
        w_ld_skid      = 1'b0;
        if (!r_out_vld || w_xfer) begin
            if (r_skid_vld) begin
                w_out_vld_nxt  = 1'b1;
                w_skid_vld_nxt = 1'b0;
                w_sel_skid     = 1'b1;
            end else begin
                w_out_vld_nxt  = w_acc;
                w_ld_in_out    = w_acc;
            end
        end else if (w_acc) begin
            w_skid_vld_nxt = 1'b1;
            w_ld_skid      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_out_vld  <= w_out_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_ready    <= !w_skid_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_sel_skid) begin
            r_out <= r_skid;
        end else if (w_ld_in_out) begin
            r_out <= w_in;
        end
        if (w_ld_skid) begin
            r_skid <= w_in;
        end
    end

    // Framing tracker follows the beat's own flags even when they are illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_flag  <= 1'b0;
        end else if (w_acc) begin
            if (avst_eop) begin
                r_state <= ST_IDLE;
            end else if (avst_sop) begin
                r_state <= ST_IN_PKT;
            end
            r_flag <= !avst_eop && (r_flag || w_viol);
        end
    end

`ifdef AVST2AXIS_PROTO_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 16'h0000;
        end else if (w_viol && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'h0001;
        end
    end

    assign proto_err_cnt = r_err_cnt;
`else
    assign proto_err_cnt = 16'h0000;
`endif

    assign avst_ready  = r_ready;
    assign axis_tvalid = r_out_vld;
    assign axis_tdata  = r_out.dat;
    assign axis_tkeep  = r_out.keep;
    assign axis_tlast  = r_out.last;
    assign axis_tuser  = r_out.user;

endmodule

// File: tb/tb_avst2axis_empty2keep.sv
// Directed bench for avst2axis_empty2keep: hand-computed beats checked against a FIFO of expected outputs.
module tb_avst2axis_empty2keep;

    typedef logic [511:0] wide_t;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } exp_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef AVST2AXIS_PROTO_CNT_EN
    localparam int EXP_CNT1 = 1;
    localparam int EXP_CNT2 = 2;
`else
    localparam int EXP_CNT1 = 0;
    localparam int EXP_CNT2 = 0;
`endif

    logic         clk;
    logic         rst_n;
    logic         avst_valid;
    logic         avst_ready;
    logic [511:0] avst_data;
    logic         avst_sop;
    logic         avst_eop;
    logic [5:0]   avst_empty;
    logic         avst_error;
    logic         axis_tvalid;
    logic         axis_tready;
    logic [511:0] axis_tdata;
    logic [63:0]  axis_tkeep;
    logic         axis_tlast;
    logic         axis_tuser;
    logic [15:0]  proto_err_cnt;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   occ    = 0;
    logic mon_en = 1'b0;
    logic tr_mode = 1'b0;
    exp_t q[$];

    avst2axis_empty2keep dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .avst_valid    (avst_valid),
        .avst_ready    (avst_ready),
        .avst_data     (avst_data),
        .avst_sop      (avst_sop),
        .avst_eop      (avst_eop),
        .avst_empty    (avst_empty),
        .avst_error    (avst_error),
        .axis_tvalid   (axis_tvalid),
        .axis_tready   (axis_tready),
        .axis_tdata    (axis_tdata),
        .axis_tkeep    (axis_tkeep),
        .axis_tlast    (axis_tlast),
        .axis_tuser    (axis_tuser),
        .proto_err_cnt (proto_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input wide_t got, input wide_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [511:0] mkd(input int n);
        return {16{n}};
    endfunction

    // Present one beat, wait (bounded) for it to be accepted, then drop valid.
    task automatic send(input logic [511:0] d, input logic sop, input logic eop,
                        input logic [5:0] emp, input logic err,
                        input logic [63:0] k, input logic u);
        int t;
        exp_t e;
        e.d = d; e.k = k; e.l = eop; e.u = u;
        q.push_back(e);
        avst_valid = 1'b1; avst_data = d; avst_sop = sop; avst_eop = eop;
        avst_empty = emp; avst_error = err;
        t = 0;
        @(negedge clk);
        while (!avst_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", wide_t'(0), wide_t'(1));
        @(posedge clk);
        #1;
        avst_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain", wide_t'(q.size()), wide_t'(0));
        @(posedge clk);
        #1;
    endtask

    // tready pattern 1,0,0,1 while tr_mode is set; updated 1 time unit after each edge.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tr_mode) begin
                axis_tready = (k % 4 == 0) || (k % 4 == 3);
                k++;
            end
        end
    end

    // Output monitor: occupancy model plus expected-beat scoreboard, sampled on the falling edge.
    initial begin
        exp_t  e;
        logic  held;
        wide_t held_d;
        held = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                chk("ready_vs_occ", wide_t'(avst_ready), wide_t'(occ < 2));
                chk("tvalid_vs_occ", wide_t'(axis_tvalid), wide_t'(occ != 0));
                if (held) begin
                    chk("stall_tvalid", wide_t'(axis_tvalid), wide_t'(1));
                    chk("stall_tdata", axis_tdata, held_d);
                end
                held = axis_tvalid && !axis_tready;
                held_d = axis_tdata;
                if (axis_tvalid && axis_tready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", wide_t'(1), wide_t'(0));
                    end else begin
                        e = q.pop_front();
                        chk("tdata", axis_tdata, e.d);
                        chk("tkeep", wide_t'(axis_tkeep), wide_t'(e.k));
                        chk("tlast", wide_t'(axis_tlast), wide_t'(e.l));
                        chk("tuser", wide_t'(axis_tuser), wide_t'(e.u));
                    end
                end
                occ = occ + int'(avst_valid && avst_ready) - int'(axis_tvalid && axis_tready);
            end else begin
                occ = 0;
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; avst_valid = 1'b0; avst_data = '0; avst_sop = 1'b0;
        avst_eop = 1'b0; avst_empty = '0; avst_error = 1'b0; axis_tready = 1'b0;

        #12;
        chk("rst_tvalid", wide_t'(axis_tvalid), wide_t'(0));
        chk("rst_ready", wide_t'(avst_ready), wide_t'(0));
        chk("rst_cnt", wide_t'(proto_err_cnt), wide_t'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", wide_t'(avst_ready), wide_t'(0));
        @(posedge clk);
        #1;
        chk("ready_after_release", wide_t'(avst_ready), wide_t'(1));
        axis_tready = 1'b1;
        mon_en = 1'b1;

        // Single SOP+EOP beat, empty=5, one cycle latency.
        send(mkd(1), 1, 1, 6'd5, 0, 64'h07FF_FFFF_FFFF_FFFF, 0);
        @(negedge clk);
        chk("lat1_tvalid", wide_t'(axis_tvalid), wide_t'(1));
        chk("lat1_tkeep", wide_t'(axis_tkeep), wide_t'(64'h07FF_FFFF_FFFF_FFFF));
        chk("lat1_tuser", wide_t'(axis_tuser), wide_t'(0));
        @(posedge clk);
        #1;
        // Maximum empty leaves only byte 0.
        send(mkd(2), 1, 1, 6'd63, 0, 64'h0000_0000_0000_0001, 0);
        // 3-beat packet; empty on a non-EOP beat is ignored.
        send(mkd(3), 1, 0, 6'd0, 0, ONES, 0);
        send(mkd(4), 0, 0, 6'd7, 0, ONES, 0);
        send(mkd(5), 0, 1, 6'd0, 0, ONES, 0);
        // avst_error surfaces on tuser.
        send(mkd(6), 1, 1, 6'd0, 1, ONES, 1);
        drain();

        // 10-beat stream under a 1,0,0,1 tready pattern.
        tr_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(mkd(100 + i), (i == 0), (i == 9), (i == 9) ? 6'd8 : 6'd0, 0,
                 (i == 9) ? 64'h00FF_FFFF_FFFF_FFFF : ONES, 0);
        end
        drain();
        @(posedge clk);
        #2;
        tr_mode = 1'b0;
        axis_tready = 1'b1;

        // SOP inside a packet: forwarded, error reported on the EOP beat.
        send(mkd(11), 1, 0, 6'd0, 0, ONES, 0);
        send(mkd(12), 0, 0, 6'd0, 0, ONES, 0);
        send(mkd(13), 1, 0, 6'd0, 0, ONES, 0);
        send(mkd(14), 0, 1, 6'd4, 0, 64'h0FFF_FFFF_FFFF_FFFF, 1);
        drain();
        chk("cnt_after_sop_viol", wide_t'(proto_err_cnt), wide_t'(EXP_CNT1));
        // Flag was cleared by the EOP; a clean packet carries no error.
        send(mkd(15), 1, 1, 6'd0, 0, ONES, 0);
        // EOP without SOP while idle is itself a violation.
        send(mkd(16), 0, 1, 6'd0, 0, ONES, 1);
        drain();
        chk("cnt_after_nosop_viol", wide_t'(proto_err_cnt), wide_t'(EXP_CNT2));

        // Reset mid-packet with the skid entry full.
        axis_tready = 1'b0;
        send(mkd(17), 1, 0, 6'd0, 0, ONES, 0);
        send(mkd(18), 0, 0, 6'd0, 0, ONES, 0);
        avst_valid = 1'b1; avst_data = mkd(19); avst_sop = 1'b0; avst_eop = 1'b0;
        @(negedge clk);
        chk("skid_full_ready", wide_t'(avst_ready), wide_t'(0));
        chk("skid_full_tvalid", wide_t'(axis_tvalid), wide_t'(1));
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", wide_t'(axis_tvalid), wide_t'(0));
        chk("arst_ready", wide_t'(avst_ready), wide_t'(0));
        chk("arst_cnt", wide_t'(proto_err_cnt), wide_t'(0));
        q.delete();
        avst_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_hold_ready", wide_t'(avst_ready), wide_t'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rerelease", wide_t'(avst_ready), wide_t'(1));
        chk("tvalid_after_rerelease", wide_t'(axis_tvalid), wide_t'(0));
        axis_tready = 1'b1;
        mon_en = 1'b1;
        // FSM must be idle: this SOP is legal.
        send(mkd(20), 1, 1, 6'd0, 0, ONES, 0);
        drain();
        chk("cnt_after_reset", wide_t'(proto_err_cnt), wide_t'(0));
        chk("final_queue_empty", wide_t'(q.size()), wide_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avst2axis_empty2keep.md
AVST2AXIS_EMPTY2KEEP -- requirements
Module: avst2axis_empty2keep

Interface
REQ-001 Parameter DATA_W, default 512, data bus width in bits.
REQ-002 Parameter NO_OF_BYTES, default 64, equals DATA_W/8.
REQ-003 Parameter EMPTY_BITS, default 6, equals log2(NO_OF_BYTES).
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 avst_valid  in  1  Avalon-ST sink valid (ready latency 0).
REQ-007 avst_ready  out  1  Avalon-ST sink ready.
REQ-008 avst_data  in  DATA_W  beat data.
REQ-009 avst_sop / avst_eop  in  1 each  start / end of packet.
REQ-010 avst_empty  in  EMPTY_BITS  count of unused bytes in an EOP beat.
REQ-011 avst_error  in  1  packet error flag, sampled on EOP beat.
REQ-012 axis_tvalid / axis_tready  out / in  1 each  AXI-S master handshake.
REQ-013 axis_tdata  out  DATA_W  beat data.
REQ-014 axis_tkeep  out  NO_OF_BYTES  byte enables.
REQ-015 axis_tlast  out  1  last beat.
REQ-016 axis_tuser  out  1  error: avst_error, or protocol violation, on the tlast beat.
REQ-017 proto_err_cnt  out  16  saturating protocol-violation count (see Configuration).

Function
REQ-018 Input beat accepted when avst_valid && avst_ready; output beat transferred when axis_tvalid && axis_tready.
REQ-019 Block SHALL be a 2-entry skid buffer (output register plus skid register); every output is registered.
REQ-020 Accepted beat SHALL appear on axis_* no earlier than the next cycle; latency is 1 cycle when the output register is free.
REQ-021 avst_ready SHALL be registered and equal 1 only while the skid register is empty; with axis_tready held high, throughput is 1 beat/cycle.
REQ-022 Beat order SHALL be preserved; no beat is dropped or duplicated under any tready pattern.
REQ-023 axis_tvalid SHALL stay high, and tdata/tkeep/tlast/tuser stable, until the beat transfers.
REQ-024 Non-EOP beat: tkeep SHALL be all ones and tlast 0.
REQ-025 EOP beat: tlast 1; tkeep[i] = 1 for i < NO_OF_BYTES-avst_empty, else 0 (empty 0 -> all ones; empty NO_OF_BYTES-1 -> only bit 0).
REQ-026 Packet FSM, two states: IDLE and IN_PKT. IDLE->IN_PKT on an accepted SOP beat without EOP; IN_PKT->IDLE on an accepted EOP beat; accepted SOP+EOP beat stays in IDLE.
REQ-027 Violation: accepted beat without SOP in IDLE, or accepted SOP beat in IN_PKT. The beat SHALL still be forwarded, and the FSM SHALL follow the beat's SOP/EOP flags.
REQ-028 A violation SHALL set a sticky flag, cleared at EOP. axis_tuser on the EOP beat = avst_error OR flag OR violation on that beat.
REQ-029 axis_tuser SHALL be 0 on non-EOP beats.
REQ-030 Simultaneous input accept and output transfer with skid empty SHALL load the output register directly and keep avst_ready 1.

Reset
REQ-031 rst_n low SHALL, asynchronously, clear axis_tvalid, avst_ready, both buffer valid bits, sticky flag and proto_err_cnt, and force FSM to IDLE.
REQ-032 avst_ready SHALL rise on the first clk edge after rst_n deasserts; a beat in flight when reset asserts is discarded.
REQ-033 Data registers need no reset; tdata/tkeep/tlast/tuser are don't-care while axis_tvalid is 0.

Configuration
REQ-034 Macro AVST2AXIS_PROTO_CNT_EN: when defined, proto_err_cnt SHALL increment by 1 per violation and saturate at 16'hFFFF.
REQ-035 When the macro is undefined, proto_err_cnt SHALL be constant 0 and no counter logic is built; REQ-027/028 behaviour is unchanged.

Verification
REQ-036 Single beat SOP+EOP, empty=5, tready=1 -> one cycle later tvalid=1, tlast=1, tkeep=64'h07FF_FFFF_FFFF_FFFF, tuser=0.
REQ-037 3-beat packet, empty=0 on EOP, tready=1 throughout -> 3 consecutive output beats, tkeep all ones each, tlast on beat 3 only.
REQ-038 Stream 10 beats while tready toggles 1,0,0,1 repeatedly -> all 10 beats out in order, avst_ready=0 only while skid is full, no loss.
REQ-039 SOP, data, SOP (no EOP), EOP -> all 4 beats forwarded, tuser=1 on the final EOP beat, proto_err_cnt=1 (macro defined) / 0 (undefined).
REQ-040 rst_n asserted mid-packet with skid full -> tvalid=0 and avst_ready=0 immediately; avst_ready=1 one cycle after release; FSM in IDLE (next SOP beat causes no violation).
